// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader and its output buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage : fifo_rd_pkg

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer between FIFO read data and the valid/ready stream.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [SKID_CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == SKID_CNT_W'(SKID_DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full buffer is only safe when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // NOTE: the storage is reset as well because the stream data must read as zero
  // out of reset; a deeper buffer would normally leave its storage unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + SKID_CNT_W'(1);
        2'b01:   count <= count - SKID_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : rd_skid_buf

// File: rtl/fifo_stream_reader.sv
// Pops a burst of `len` words from the synchronous FIFO onto a valid/ready stream.
// Define READ_CNT_EN to add the rd_count output (stream handshakes since reset).
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef READ_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  rd_state_e             state;
  rd_state_e             state_nxt;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic                  inflight;
  logic                  pop;
  logic                  rd_issue;
  logic                  credit_ok;
  logic                  drain_last;
  logic [2:0]            occupancy;
  logic [SKID_CNT_W-1:0] buf_count;
  logic                  buf_full;
  logic                  buf_empty;

  assign pop       = m_valid && m_ready;
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  // At most two words may be buffered or in flight once this edge has settled.
  assign credit_ok = buf_full ? (pop && !inflight) : (occupancy < 3'd2);
  assign rd_issue  = (state == RUN) && (issue_cnt != '0) && !fifo_empty && credit_ok;
  // The buffer is empty after this edge: nothing in flight and the last word leaving.
  assign drain_last = !inflight &&
                      (buf_empty || ((buf_count == SKID_CNT_W'(1)) && pop));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    fifo_cs    = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        fifo_cs    = 1'b1;
        fifo_rd_en = rd_issue;
        if ((issue_cnt == '0) ||
            (rd_issue && (issue_cnt == LEN_WIDTH'(1)))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        fifo_cs = 1'b1;
        if (drain_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        issue_cnt <= len;
      end else if (rd_issue) begin
        issue_cnt <= issue_cnt - LEN_WIDTH'(1);
      end
      // FIFO read data is registered, so it is valid the cycle after the issue.
      inflight <= rd_issue;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign m_valid = !buf_empty;

`ifdef READ_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and an output scoreboard.
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          start   = 1'b0;
  logic [LW-1:0] len     = '0;
  logic          m_ready = 1'b1;
  logic          busy, done, fifo_cs, fifo_rd_en, m_valid;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data, m_data;
`ifdef READ_CNT_EN
  logic [15:0]   rd_count;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef READ_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  int            n_tests   = 0;
  int            n_fail    = 0;
  int            hs_count  = 0;
  int            rd_issued = 0;
  int            rst_base  = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          push_en   = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural synchronous FIFO: registered read data, empty flag updated at the edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_cs && fifo_rd_en && (fq.size() != 0)) fifo_data <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Stream monitor: protocol rules every cycle, data order against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_rd_en) begin
        rd_issued++;
        check("rd_en_while_empty", 32'(fifo_empty), 0);
        check("rd_en_without_cs", 32'(fifo_cs), 1);
      end
      if (prev_stall) begin
        check("stall_valid_hold", 32'(m_valid), 1);
        check("stall_data_hold", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check("sb_underrun", 32'(exp_q.size()), 1);
        else check("data_order", 32'(m_data), 32'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit expect_out);
    push_en   = 1'b1;
    push_data = d;
    if (expect_out) exp_q.push_back(d);
    step();
    push_en = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(tag, 32'(seen), 1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_done"},    32'(done), 0);
    check({tag, "_cs"},      32'(fifo_cs), 0);
    check({tag, "_rd_en"},   32'(fifo_rd_en), 0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_data"},  32'(m_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rd_mask, mv_mask, dn_mask, bz_mask;
    logic [2:0] dn4_mask, bz4_mask;
    int         base;
    bit         reached;

    step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // 1: four preloaded words at full rate.
    push_word(16'h1111, 1);
    push_word(16'h2222, 1);
    push_word(16'h3333, 1);
    push_word(16'h4444, 1);
    rd_mask = 9'b000011110;
    mv_mask = 9'b001111000;
    dn_mask = 9'b010000000;
    bz_mask = 9'b011111110;
    start = 1'b1;
    len   = 8'd4;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("t1_rd_en_c%0d", c),   32'(fifo_rd_en), 32'(rd_mask[c]));
      check($sformatf("t1_m_valid_c%0d", c), 32'(m_valid),    32'(mv_mask[c]));
      check($sformatf("t1_done_c%0d", c),    32'(done),       32'(dn_mask[c]));
      check($sformatf("t1_busy_c%0d", c),    32'(busy),       32'(bz_mask[c]));
      step();
      if (c == 0) start = 1'b0;
    end
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // 2: backpressure from the start; only two reads may be outstanding.
    for (int i = 0; i < 6; i++) push_word(16'hA000 + 16'(i), 1);
    m_ready = 1'b0;
    base    = rd_issued;
    start   = 1'b1;
    len     = 8'd6;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      step();
      if (c == 0) start = 1'b0;
    end
    check("t2_reads_stalled", 32'(rd_issued - base), 2);
    check("t2_rd_en_stalled", 32'(fifo_rd_en), 0);
    check("t2_head_valid", 32'(m_valid), 1);
    check("t2_head_data", 32'(m_data), 32'h0000A000);
    m_ready = 1'b1;
    wait_done(40, "t2_done");
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    check("t2_reads_total", 32'(rd_issued - base), 6);

    // 3: FIFO starts empty; words trickle in.
    base  = hs_count;
    start = 1'b1;
    len   = 8'd3;
    step();
    start = 1'b0;
    @(negedge clk);
    check("t3_busy", 32'(busy), 1);
    check("t3_no_rd_while_empty", 32'(fifo_rd_en), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      repeat (3) step();
      push_word(16'hC000 + 16'(k), 1);
      @(negedge clk);
      check($sformatf("t3_rd_after_push%0d", k), 32'(fifo_rd_en), 1);
      step();
    end
    wait_done(20, "t3_done");
    check("t3_handshakes", 32'(hs_count - base), 3);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // 4: zero-length burst.
    dn4_mask = 3'b010;
    bz4_mask = 3'b010;
    start = 1'b1;
    len   = 8'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t4_rd_en_c%0d", c),   32'(fifo_rd_en), 0);
      check($sformatf("t4_m_valid_c%0d", c), 32'(m_valid), 0);
      check($sformatf("t4_done_c%0d", c),    32'(done), 32'(dn4_mask[c]));
      check($sformatf("t4_busy_c%0d", c),    32'(busy), 32'(bz4_mask[c]));
      step();
      if (c == 0) start = 1'b0;
    end
    check("t1_4_handshakes", 32'(hs_count), 13);
`ifdef READ_CNT_EN
    check("rd_count_t1_4", 32'(rd_count), 13);
`endif

    // 5: reset in the middle of a burst, then a fresh burst.
    for (int i = 0; i < 5; i++) push_word(16'h5000 + 16'(i), 1);
    base  = hs_count;
    start = 1'b1;
    len   = 8'd5;
    step();
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      @(negedge clk);
      reached = (hs_count - base >= 2);
    end
    check("t5_two_handshakes", 32'(reached), 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    exp_q.delete();
    rst_base = hs_count;
    step();
    rstn = 1'b1;
    step();
    push_word(16'h6000, 1);
    push_word(16'h6001, 1);
    start = 1'b1;
    len   = 8'd2;
    step();
    start = 1'b0;
    wait_done(20, "t5_done");
    check("t5_handshakes", 32'(hs_count - rst_base), 2);
    check("t5_sb_empty", 32'(exp_q.size()), 0);

    // 6: start re-asserted mid-burst must not change the length.
    for (int i = 0; i < 10; i++) push_word(16'h7000 + 16'(i), i < 3);
    base  = hs_count;
    start = 1'b1;
    len   = 8'd3;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    len   = 8'd7;
    step();
    start = 1'b0;
    wait_done(30, "t6_done");
    check("t6_handshakes", 32'(hs_count - base), 3);
    check("t6_sb_empty", 32'(exp_q.size()), 0);
    check("t6_fifo_left", 32'(fq.size()), 7);
    @(negedge clk);
    check("t6_idle", 32'(busy), 0);
`ifdef READ_CNT_EN
    check("rd_count_after_reset", 32'(rd_count), 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_stream_reader

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO (chip-select, rd_en, empty, registered read data with 1-cycle latency).
- On a start command it pops exactly `len` words from the FIFO.
- Popped words are presented on a valid/ready output stream at full throughput, with no loss or duplication under backpressure.
- Sits between the FIFO and any downstream consumer (packetiser, DMA sink).

Parameters:
- DATA_WIDTH, 16, width of FIFO data and output stream data.
- LEN_WIDTH, 8, width of the burst length field; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  burst request pulse; sampled only in IDLE.
- len  input  LEN_WIDTH  number of words to pop; sampled with start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  single-cycle pulse when the burst is complete.
- fifo_cs  output  1  FIFO chip select.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- m_valid  output  1  output stream valid.
- m_data  output  DATA_WIDTH  output stream data.
- m_ready  input  1  output stream ready.

Behaviour:
- Reset (rstn low, asynchronous):
  - busy, done, fifo_cs, fifo_rd_en, m_valid = 0; m_data = 0.
  - Issue counter, in-flight flag, buffer count and FSM (IDLE) cleared.
  - Reset mid-burst abandons the burst silently; the FIFO is reset by the same rstn.
- FSM states:
  - IDLE: start && len!=0 -> RUN, load issue counter = len. start && len==0 -> DONE.
  - RUN: when the last read is issued (issue counter reaches 0) -> DRAIN.
  - DRAIN: when in-flight==0 && buffer empty -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- start in any state other than IDLE is ignored.
- fifo_cs = 1 in RUN and DRAIN, else 0.
- Read issue (fifo_rd_en, combinational):
  - Asserted when state==RUN, issue counter!=0, !fifo_empty, and (buf_count + inflight - pop) < 2, where pop = m_valid && m_ready.
  - Never assert rd_en while fifo_empty.
  - Each issue decrements the issue counter and sets inflight for the next cycle.
- Capture: when inflight==1, fifo_data is written into a 2-entry output buffer on that clock edge.
- Latency: rd_en high in cycle N -> word on m_data with m_valid in cycle N+2.
- Throughput: sustained 1 word/cycle while the FIFO is non-empty and m_ready=1.
- Output stream:
  - m_valid = buffer non-empty; m_data = buffer head.
  - m_valid && !m_ready -> m_valid and m_data hold stable.
  - m_valid never drops without a handshake.
- Simultaneous capture and pop in one cycle is legal; buffer count is unchanged.
- Buffer never overflows: the credit rule guarantees at most 2 words buffered or in flight.
- Words are delivered in FIFO order, exactly `len` words per burst.

Optional Feature:
- Macro: READ_CNT_EN.
- Defined:
  - Extra output rd_count, 16 bits: total words handshaked on the output stream since reset.
  - Increments on m_valid && m_ready; wraps 0xFFFF -> 0; cleared only by rstn.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fifo_rd_pkg:
  - FSM state enum, 2 bits: IDLE, RUN, DRAIN, DONE.
  - Localparam SKID_DEPTH = 2.
- Sub-module rd_skid_buf:
  - 2-entry buffer with push, pop, count, head data and full/empty.
  - Instantiated once; FSM, credit and issue logic stay in the top module.

Test Plan:
1. FIFO preloaded with 0x1111, 0x2222, 0x3333, 0x4444; start, len=4 in cycle 0; m_ready=1 -> fifo_rd_en high cycles 1-4; m_valid cycles 3-6 with data in order; done pulse cycle 7; busy low cycle 8.
2. FIFO holds 6 words; len=6; m_ready=0 cycles 0-9 -> exactly 2 reads issued, then rd_en=0; m_data=first word held stable; after m_ready=1 all 6 words delivered once, in order.
3. FIFO empty; start, len=3 -> busy=1, rd_en=0; push one word every 4 cycles -> each is read 1 cycle after empty falls; 3 words delivered; done after the third handshake.
4. start with len=0 -> no rd_en, no m_valid; done pulse cycle 1; busy high cycle 1 only.
5. len=5; rstn pulsed low after 2 handshakes -> all outputs 0 immediately; after release, new start len=2 with a freshly loaded FIFO delivers exactly 2 correct words.
6. start re-asserted while busy with len=7 -> ignored, original burst length honoured; READ_CNT_EN build: rd_count equals total handshakes across tests 1-4.
